// File: rtl/chip8_alu_sequencer_pkg.sv
// Shared types for the Chip-8 8XYN ALU sequencer.
// ALU function codes, FSM states and opcode decode bundle.
package chip8_alu_sequencer_pkg;

  typedef enum logic [2:0] {
    ALU_NOP,
    ALU_OR,
    ALU_AND,
    ALU_XOR,
    ALU_ADD,
    ALU_MINUS,
    ALU_RSHIFT,
    ALU_LSHIFT
  } ALU_f;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_X,
    S_RD_Y,
    S_EXEC,
    S_WR_X,
    S_WR_F,
    S_DONE
  } seq_state_t;

  typedef enum logic [2:0] {
    FLAG_ZERO,
    FLAG_CARRY,
    FLAG_GE,
    FLAG_LSB,
    FLAG_MSB
  } flag_src_t;

  typedef struct packed {
    ALU_f      alu_sel;
    logic      swap_operands;
    logic      is_shift;
    logic      writes_vf;
    flag_src_t flag_src;
    logic      illegal;
  } op_dec_t;

  localparam logic [3:0]  OPC_ARITH = 4'h8;
  localparam logic [15:0] SHIFT_AMT = 16'd1;

endpackage

// File: rtl/chip8_alu_sequencer_if.sv
// Bus bundle between the sequencer and decode/regfile/ALU.
// slave = sequencer side, master = environment side.
interface chip8_alu_sequencer_if #(
  parameter int REG_W = 8
);
  import chip8_alu_sequencer_pkg::*;

  logic             start;
  logic [15:0]      opcode;
  logic             ready;
  logic             done;
  logic             illegal;
  logic [3:0]       reg_raddr;
  logic [REG_W-1:0] reg_rdata;
  logic             reg_we;
  logic [3:0]       reg_waddr;
  logic [REG_W-1:0] reg_wdata;
  ALU_f             alu_sel;
  logic [15:0]      alu_in1;
  logic [15:0]      alu_in2;
  logic [15:0]      alu_out;
  logic             alu_carry;

  modport slave (
    input  start, opcode, reg_rdata,
    input  alu_out, alu_carry,
    output ready, done, illegal,
    output reg_raddr, reg_we,
    output reg_waddr, reg_wdata,
    output alu_sel, alu_in1, alu_in2
  );

  modport master (
    output start, opcode, reg_rdata,
    output alu_out, alu_carry,
    input  ready, done, illegal,
    input  reg_raddr, reg_we,
    input  reg_waddr, reg_wdata,
    input  alu_sel, alu_in1, alu_in2
  );

endinterface

// File: rtl/chip8_alu_sequencer_op_decode.sv
// Maps the N nibble of 8XYN to ALU/flag controls.
// CHIP8_VF_RESET_QUIRK_EN: OR/AND/XOR also clear VF.
module chip8_alu_op_decode
  import chip8_alu_sequencer_pkg::*;
(
  input  logic [3:0] n,
  output op_dec_t    dec
);

`ifdef CHIP8_VF_RESET_QUIRK_EN
  localparam logic LOGIC_VF = 1'b1;
`else
  localparam logic LOGIC_VF = 1'b0;
`endif

  // per-N control table
  always_comb begin
    dec = '0;
    unique case (n)
      4'h0: dec.alu_sel = ALU_NOP;
      4'h1: begin
        dec.alu_sel   = ALU_OR;
        dec.writes_vf = LOGIC_VF;
      end
      4'h2: begin
        dec.alu_sel   = ALU_AND;
        dec.writes_vf = LOGIC_VF;
      end
      4'h3: begin
        dec.alu_sel   = ALU_XOR;
        dec.writes_vf = LOGIC_VF;
      end
      4'h4: begin
        dec.alu_sel   = ALU_ADD;
        dec.writes_vf = 1'b1;
        dec.flag_src  = FLAG_CARRY;
      end
      4'h5: begin
        dec.alu_sel   = ALU_MINUS;
        dec.writes_vf = 1'b1;
        dec.flag_src  = FLAG_GE;
      end
      4'h6: begin
        dec.alu_sel   = ALU_RSHIFT;
        dec.is_shift  = 1'b1;
        dec.writes_vf = 1'b1;
        dec.flag_src  = FLAG_LSB;
      end
      4'h7: begin
        dec.alu_sel       = ALU_MINUS;
        dec.swap_operands = 1'b1;
        dec.writes_vf     = 1'b1;
        dec.flag_src      = FLAG_GE;
      end
      4'hE: begin
        dec.alu_sel   = ALU_LSHIFT;
        dec.is_shift  = 1'b1;
        dec.writes_vf = 1'b1;
        dec.flag_src  = FLAG_MSB;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/chip8_alu_sequencer.sv
// Chip-8 8XYN sequencer: read VX/VY, run ALU, write VX then VF.
// CHIP8_VF_RESET_QUIRK_EN (in op decode) clears VF on OR/AND/XOR.
module chip8_alu_sequencer
  import chip8_alu_sequencer_pkg::*;
#(
  parameter logic [3:0] VF_INDEX = 4'hF,
  parameter int          REG_W    = 8
) (
  input logic                  clk,
  input logic                  reset,
  chip8_alu_sequencer_if.slave bus
);

  seq_state_t       state;
  seq_state_t       state_nx;
  logic [3:0]       x_q;
  logic [3:0]       y_q;
  logic [3:0]       n_q;
  logic             ill_q;
  logic [REG_W-1:0] vx_q;
  logic [REG_W-1:0] res_q;
  logic             flag_q;

  logic [3:0]       n_dec;
  op_dec_t          dec;
  logic             accept;
  logic             bad_opc;
  logic [REG_W-1:0] vy;
  logic [REG_W-1:0] op_a;
  logic [REG_W-1:0] op_b;
  logic [REG_W-1:0] res_nx;
  logic             flag_nx;
  logic             unused_bits;

  assign accept  = (state == S_IDLE) && bus.start;
  assign n_dec   = (state == S_IDLE) ? bus.opcode[3:0] : n_q;
  assign bad_opc = (bus.opcode[15:12] != OPC_ARITH) || dec.illegal;

  chip8_alu_op_decode u_dec (
    .n   (n_dec),
    .dec (dec)
  );

  assign vy   = bus.reg_rdata;
  assign op_a = dec.swap_operands ? vy : vx_q;
  assign op_b = dec.swap_operands ? vx_q : vy;

  assign unused_bits = ^bus.alu_out[15:REG_W];

  // result and flag as seen during EXEC
  always_comb begin
    res_nx = (dec.alu_sel == ALU_NOP) ? vy : bus.alu_out[REG_W-1:0];
    unique case (dec.flag_src)
      FLAG_CARRY: flag_nx = bus.alu_carry;
      FLAG_GE:    flag_nx = (op_a >= op_b);
      FLAG_LSB:   flag_nx = vx_q[0];
      FLAG_MSB:   flag_nx = vx_q[REG_W-1];
      default:    flag_nx = 1'b0;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:
        if (accept) state_nx = bad_opc ? S_DONE : S_RD_X;
      S_RD_X: state_nx = S_RD_Y;
      S_RD_Y: state_nx = S_EXEC;
      S_EXEC: state_nx = S_WR_X;
      S_WR_X: state_nx = dec.writes_vf ? S_WR_F : S_DONE;
      S_WR_F: state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // instruction fields and operand/result capture
  always_ff @(posedge clk) begin
    if (!reset) begin
      x_q    <= '0;
      y_q    <= '0;
      n_q    <= '0;
      ill_q  <= 1'b0;
      vx_q   <= '0;
      res_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          x_q   <= bus.opcode[11:8];
          y_q   <= bus.opcode[7:4];
          n_q   <= bus.opcode[3:0];
          ill_q <= bad_opc;
        end
        S_RD_Y: vx_q <= bus.reg_rdata;
        S_EXEC: begin
          res_q  <= res_nx;
          flag_q <= flag_nx;
        end
        default: ;
      endcase
    end
  end

  // state-decoded outputs; writes are cut as soon as reset drops
  always_comb begin
    bus.ready     = 1'b0;
    bus.done      = 1'b0;
    bus.illegal   = 1'b0;
    bus.reg_raddr = '0;
    bus.reg_we    = 1'b0;
    bus.reg_waddr = '0;
    bus.reg_wdata = '0;
    bus.alu_sel   = ALU_NOP;
    bus.alu_in1   = '0;
    bus.alu_in2   = '0;
    case (state)
      S_IDLE: bus.ready = 1'b1;
      S_RD_X: bus.reg_raddr = x_q;
      S_RD_Y: bus.reg_raddr = y_q;
      S_EXEC: begin
        bus.alu_sel = dec.alu_sel;
        if (dec.alu_sel != ALU_NOP) begin
          bus.alu_in1 = {{(16-REG_W){1'b0}}, op_a};
          bus.alu_in2 = dec.is_shift ? SHIFT_AMT
                      : {{(16-REG_W){1'b0}}, op_b};
        end
      end
      S_WR_X: begin
        bus.reg_we    = reset;
        bus.reg_waddr = x_q;
        bus.reg_wdata = res_q;
      end
      S_WR_F: begin
        bus.reg_we    = reset;
        bus.reg_waddr = VF_INDEX;
        bus.reg_wdata = {{(REG_W-1){1'b0}}, flag_q};
      end
      S_DONE: begin
        bus.done    = 1'b1;
        bus.illegal = ill_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_chip8_alu_sequencer.sv
// Bench for chip8_alu_sequencer: regfile/ALU models plus
// an instruction-level reference model of 8XYN semantics.
module tb_chip8_alu_sequencer;
  import chip8_alu_sequencer_pkg::*;

`ifdef CHIP8_VF_RESET_QUIRK_EN
  localparam bit QUIRK = 1'b1;
`else
  localparam bit QUIRK = 1'b0;
`endif

  logic clk;
  logic reset;
  int   total;
  int   bad;

  chip8_alu_sequencer_if #(.REG_W(8)) bus ();

  chip8_alu_sequencer #(.VF_INDEX(4'hF), .REG_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  rf [16];
  logic [11:0] wlog [$];
  logic        poke_en;
  logic [3:0]  poke_a;
  logic [7:0]  poke_d;

  always @(posedge clk) begin
    bus.reg_rdata <= rf[bus.reg_raddr];
    if (poke_en) rf[poke_a] <= poke_d;
    else if (bus.reg_we) begin
      rf[bus.reg_waddr] <= bus.reg_wdata;
      wlog.push_back({bus.reg_waddr, bus.reg_wdata});
    end
  end

  logic [15:0] asum;
  always_comb begin
    asum          = '0;
    bus.alu_out   = '0;
    bus.alu_carry = 1'b0;
    case (bus.alu_sel)
      ALU_OR:     bus.alu_out = bus.alu_in1 | bus.alu_in2;
      ALU_AND:    bus.alu_out = bus.alu_in1 & bus.alu_in2;
      ALU_XOR:    bus.alu_out = bus.alu_in1 ^ bus.alu_in2;
      ALU_ADD: begin
        asum          = bus.alu_in1 + bus.alu_in2;
        bus.alu_out   = asum;
        bus.alu_carry = asum[8];
      end
      ALU_MINUS:  bus.alu_out = bus.alu_in1 - bus.alu_in2;
      ALU_RSHIFT: bus.alu_out = bus.alu_in1 >> bus.alu_in2;
      ALU_LSHIFT: bus.alu_out = bus.alu_in1 << bus.alu_in2;
      default:    bus.alu_out = '0;
    endcase
  end

  logic [7:0]  mreg [16];
  logic [11:0] exp_w [$];
  time         done_t;

  task automatic poke(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    poke_a = a; poke_d = d; poke_en = 1'b1;
    @(posedge clk); #1;
    poke_en = 1'b0;
    mreg[a] = d;
  endtask

  task automatic model_run(input logic [15:0] op,
                           output int lat, output bit ill);
    logic [3:0] x, y, n;
    logic [7:0] vx, vy, r;
    logic [8:0] t;
    bit f, wf;
    x = op[11:8]; y = op[7:4]; n = op[3:0];
    vx = mreg[x]; vy = mreg[y];
    exp_w.delete();
    f = 1'b0; wf = 1'b1; ill = 1'b0; r = vx;
    case (n)
      4'h0: begin r = vy; wf = 1'b0; end
      4'h1: begin r = vx | vy; wf = QUIRK; end
      4'h2: begin r = vx & vy; wf = QUIRK; end
      4'h3: begin r = vx ^ vy; wf = QUIRK; end
      4'h4: begin t = {1'b0, vx} + {1'b0, vy}; r = t[7:0]; f = t[8]; end
      4'h5: begin r = vx - vy; f = (vx >= vy); end
      4'h7: begin r = vy - vx; f = (vy >= vx); end
      4'h6: begin r = vx / 2; f = vx[0]; end
      4'hE: begin r = vx * 2; f = vx[7]; end
      default: ill = 1'b1;
    endcase
    if (op[15:12] != 4'h8) ill = 1'b1;
    if (ill) begin
      lat = 1;
    end else begin
      mreg[x] = r;
      exp_w.push_back({x, r});
      if (wf) begin
        mreg[15] = {7'd0, f};
        exp_w.push_back({4'hF, 7'd0, f});
      end
      lat = wf ? 6 : 5;
    end
  endtask

  task automatic run_dut(input logic [15:0] op,
                         output int lat, output bit ill);
    int k;
    lat = 99; ill = 1'b0; k = 0;
    @(negedge clk);
    while (bus.ready !== 1'b1 && k < 20) begin
      @(negedge clk); k++;
    end
    if (bus.ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL ready_wait got=%b want=1", bus.ready);
      return;
    end
    bus.start = 1'b1; bus.opcode = op;
    @(posedge clk); #1;
    bus.start = 1'b0;
    k = 1;
    while (bus.done !== 1'b1 && k < 20) begin
      @(posedge clk); #1; k++;
    end
    if (bus.done === 1'b1) begin
      lat = k; ill = bus.illegal; done_t = $time;
    end
  endtask

  task automatic do_op(input logic [15:0] op, input string tag);
    int lat, elat, base;
    bit ill, eill;
    base = wlog.size();
    model_run(op, elat, eill);
    run_dut(op, lat, ill);
    total++;
    if (lat !== elat) begin
      bad++;
      $display("FAIL %s latency got=%0d want=%0d", tag, lat, elat);
    end
    total++;
    if (ill !== eill) begin
      bad++;
      $display("FAIL %s illegal got=%b want=%b", tag, ill, eill);
    end
    total++;
    if (wlog.size() - base !== exp_w.size()) begin
      bad++;
      $display("FAIL %s wcount got=%0d want=%0d", tag,
               wlog.size() - base, exp_w.size());
    end else begin
      foreach (exp_w[i]) begin
        total++;
        if (wlog[base+i] !== exp_w[i]) begin
          bad++;
          $display("FAIL %s write%0d got=%h want=%h", tag, i,
                   wlog[base+i], exp_w[i]);
        end
      end
    end
    for (int r = 0; r < 16; r++) begin
      if (rf[r] !== mreg[r]) begin
        total++; bad++;
        $display("FAIL %s V%0h got=%h want=%h", tag, r, rf[r], mreg[r]);
      end
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] got,
                      input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({bus.ready, bus.done, bus.illegal, bus.reg_we} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=1000",
               {bus.ready, bus.done, bus.illegal, bus.reg_we});
    end
    total++;
    if ({bus.reg_raddr, bus.reg_waddr, bus.reg_wdata} !== 16'h0) begin
      bad++;
      $display("FAIL reset_addr got=%h want=0",
               {bus.reg_raddr, bus.reg_waddr, bus.reg_wdata});
    end
    total++;
    if (bus.alu_sel !== ALU_NOP || bus.alu_in1 !== 16'h0 ||
        bus.alu_in2 !== 16'h0) begin
      bad++;
      $display("FAIL reset_alu got=%0d/%h/%h want=0/0/0",
               bus.alu_sel, bus.alu_in1, bus.alu_in2);
    end
    reset = 1'b1;
    for (int r = 0; r < 16; r++) poke(r[3:0], 8'($urandom));
  endtask

  task automatic test_add;
    poke(4'h1, 8'hF0); poke(4'h2, 8'h20);
    do_op(16'h8124, "add");
    chk8("add_v1", rf[1], 8'h10);
    chk8("add_vf", rf[15], 8'h01);
  endtask

  task automatic test_sub;
    poke(4'h3, 8'h05); poke(4'h4, 8'h05);
    do_op(16'h8345, "sub_eq");
    chk8("sub_eq_v3", rf[3], 8'h00);
    chk8("sub_eq_vf", rf[15], 8'h01);
    poke(4'h3, 8'h04);
    do_op(16'h8345, "sub_lt");
    chk8("sub_lt_v3", rf[3], 8'hFF);
    chk8("sub_lt_vf", rf[15], 8'h00);
  endtask

  task automatic test_shl_vf;
    poke(4'hF, 8'h81);
    do_op(16'h8F0E, "shl_vf");
    chk8("shl_vf_final", rf[15], 8'h01);
    chk8("shl_vf_first", wlog[wlog.size()-2][7:0], 8'h02);
  endtask

  task automatic test_vf_quirk;
    int base;
    poke(4'h5, 8'hAA); poke(4'h6, 8'h0F); poke(4'hF, 8'h07);
    base = wlog.size();
    do_op(16'h8562, "and_quirk");
    chk8("and_v5", rf[5], 8'h0A);
    chk8("and_vf", rf[15], QUIRK ? 8'h00 : 8'h07);
    chk8("and_nw", 8'(wlog.size() - base), QUIRK ? 8'd2 : 8'd1);
  endtask

  task automatic test_illegal;
    do_op(16'h8128, "ill_n8");
    do_op(16'h7124, "ill_op7");
  endtask

  task automatic test_reset_mid;
    int base;
    poke(4'h1, 8'hF0); poke(4'h2, 8'h20);
    base = wlog.size();
    @(negedge clk);
    bus.start = 1'b1; bus.opcode = 16'h8124;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    total++;
    if (bus.ready !== 1'b1 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_state got=%b%b want=10",
               bus.ready, bus.done);
    end
    repeat (8) @(posedge clk);
    #1;
    chk8("rst_mid_nw", 8'(wlog.size() - base), 8'd0);
    chk8("rst_mid_v1", rf[1], 8'hF0);
  endtask

  task automatic test_busy_start;
    int lat, base, k;
    bit ill;
    poke(4'h1, 8'h33); poke(4'h2, 8'h44);
    base = wlog.size();
    model_run(16'h8124, lat, ill);
    @(negedge clk);
    bus.start = 1'b1; bus.opcode = 16'h8124;
    @(posedge clk); #1;
    bus.opcode = 16'h8346;
    k = 1;
    while (bus.done !== 1'b1 && k < 20) begin
      @(posedge clk); #1; k++;
    end
    bus.start = 1'b0;
    total++;
    if (k !== lat) begin
      bad++;
      $display("FAIL busy_lat got=%0d want=%0d", k, lat);
    end
    repeat (6) @(posedge clk);
    #1;
    chk8("busy_nw", 8'(wlog.size() - base), 8'(exp_w.size()));
    chk8("busy_v3", rf[3], mreg[3]);
    chk8("busy_v1", rf[1], mreg[1]);
  endtask

  task automatic test_back_to_back;
    time t0;
    int  elat, lat;
    bit  ill;
    do_op(16'h8014, "b2b_a");
    t0 = done_t;
    do_op(16'h8233, "b2b_b");
    elat = QUIRK ? 6 : 5;
    lat  = int'((done_t - t0) / 10);
    total++;
    if (lat !== elat + 1) begin
      bad++;
      $display("FAIL b2b_gap got=%0d want=%0d", lat, elat + 1);
    end
    ill = 1'b0;
    if (ill) $display("unreachable");
  endtask

  task automatic test_random;
    logic [3:0] nl [12];
    logic [3:0] hi, n;
    nl = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
           4'h6, 4'h7, 4'hE, 4'h8, 4'h9, 4'hF};
    for (int i = 0; i < 60; i++) begin
      n  = nl[$urandom_range(0, 11)];
      hi = ($urandom_range(0, 9) == 0) ? 4'h9 : 4'h8;
      if ($urandom_range(0, 4) == 0)
        poke(4'($urandom_range(0, 15)), 8'($urandom));
      do_op({hi, 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), n}, "rand");
    end
  endtask

  initial begin
    total = 0; bad = 0;
    poke_en = 1'b0; poke_a = '0; poke_d = '0;
    bus.start = 1'b0; bus.opcode = '0;
    done_t = 0;
    test_reset;
    test_add;
    test_sub;
    test_shl_vf;
    test_vf_quirk;
    test_illegal;
    test_reset_mid;
    test_busy_start;
    test_back_to_back;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
